// File: rtl/pc_redirect_ctrl.sv
// Front-end sequencing controller: turns EX branch resolution and load-use hazards into
// PC-select, IF/ID and ID/EX enables/flushes, tracks HALT/RUN and counts redirects and stalls.
module pc_redirect_ctrl #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             pc_sel,
  input  logic             j_sel,
  input  logic             jalr,
  input  logic             halt,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      alu_result,
  input  logic             ld_use,
  input  logic             resume,
  output logic [1:0]       pc_src,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  localparam logic [1:0]       PC_NEXT  = 2'd0;
  localparam logic [1:0]       PC_REDIR = 2'd1;
  localparam logic [1:0]       PC_HOLD  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] redirCnt_q, redirCnt_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic isRun, evHalt, evRedir, evStall;

  // j_sel and the high/low PC bits outside the redirect window are deliberately not used.
  logic unusedInputs;
  assign unusedInputs = ^{j_sel, br_pc[31:PC_W], alu_result[31:PC_W], alu_result[0]};

  assign isRun   = (state_q == RUN);
  assign evHalt  = isRun & ex_valid & halt;
  assign evRedir = isRun & ex_valid & ((pc_sel & ~halt) | jalr);
  assign evStall = isRun & ld_use;

  always_comb begin
    state_d     = state_q;
    redirCnt_d  = redirCnt_q;
    stallCnt_d  = stallCnt_q;
    pc_src      = PC_NEXT;
    redirect_pc = '0;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;

    if (!reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (!isRun) begin
      pc_src     = PC_HOLD;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      if (resume) begin
        state_d = RUN;
      end
    end else if (evHalt) begin
      pc_src     = PC_HOLD;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = HALTED;
    end else if (evRedir) begin
      // Any coincident load-use stall belongs to a wrong-path instruction and is dropped.
      pc_src      = PC_REDIR;
      redirect_pc = jalr ? {alu_result[PC_W-1:1], 1'b0} : br_pc[PC_W-1:0];
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      if (redirCnt_q != CNT_MAX) begin
        redirCnt_d = redirCnt_q + CNT_ONE;
      end
    end else if (evStall) begin
      pc_src     = PC_HOLD;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      if (stallCnt_q != CNT_MAX) begin
        stallCnt_d = stallCnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      redirCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      redirCnt_q <= redirCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign halted       = (state_q == HALTED);
  assign redirect_cnt = redirCnt_q;
  assign stall_cnt    = stallCnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Randomised and directed bench for pc_redirect_ctrl, checked against a rule-level model
// of the controller; a second instance with 2-bit counters exercises saturation.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, pc_sel, j_sel, jalr, halt, ld_use, resume;
  logic [31:0] br_pc, alu_result;

  logic [1:0]  pc_src;
  logic [8:0]  redirect_pc;
  logic        ifid_we, ifid_flush, idex_flush, halted;
  logic [15:0] redirect_cnt, stall_cnt;

  logic [1:0]  pcSrcS;
  logic [8:0]  redirectPcS;
  logic        ifidWeS, ifidFlushS, idexFlushS, haltedS;
  logic [1:0]  redirCntS, stallCntS;

  int total = 0;
  int bad   = 0;

  // Model state: run/halt flag and unbounded event tallies, saturated on compare.
  bit     mHalted = 1'b0;
  longint mRedir  = 0;
  longint mStall  = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.PC_W(9), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .pc_sel(pc_sel), .j_sel(j_sel),
    .jalr(jalr), .halt(halt), .br_pc(br_pc), .alu_result(alu_result), .ld_use(ld_use),
    .resume(resume), .pc_src(pc_src), .redirect_pc(redirect_pc), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  pc_redirect_ctrl #(.PC_W(9), .CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .pc_sel(pc_sel), .j_sel(j_sel),
    .jalr(jalr), .halt(halt), .br_pc(br_pc), .alu_result(alu_result), .ld_use(ld_use),
    .resume(resume), .pc_src(pcSrcS), .redirect_pc(redirectPcS), .ifid_we(ifidWeS),
    .ifid_flush(ifidFlushS), .idex_flush(idexFlushS), .halted(haltedS),
    .redirect_cnt(redirCntS), .stall_cnt(stallCntS)
  );

  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Expected combinational outputs from the current inputs and model state.
  task automatic expComb(output logic [1:0] ePc, output logic [8:0] eRpc,
                         output logic eWe, output logic eIf, output logic eId);
    ePc = 2'd0; eRpc = 9'd0; eWe = 1'b1; eIf = 1'b0; eId = 1'b0;
    if (!reset) begin
      eIf = 1'b1; eId = 1'b1;
    end else if (mHalted) begin
      ePc = 2'd2; eWe = 1'b0; eId = 1'b1;
    end else if (ex_valid && halt) begin
      ePc = 2'd2; eWe = 1'b0; eIf = 1'b1; eId = 1'b1;
    end else if (ex_valid && (pc_sel || jalr)) begin
      ePc = 2'd1; eIf = 1'b1; eId = 1'b1;
      eRpc = jalr ? 9'(((alu_result % 512) / 2) * 2) : 9'(br_pc % 512);
    end else if (ld_use) begin
      ePc = 2'd2; eWe = 1'b0; eId = 1'b1;
    end
  endtask

  task automatic drive(input bit rstN, input bit ev, input bit ps, input bit js, input bit jr,
                       input bit ht, input bit ld, input bit rs,
                       input logic [31:0] bp, input logic [31:0] alu);
    @(negedge clk);
    reset = rstN; ex_valid = ev; pc_sel = ps; j_sel = js; jalr = jr; halt = ht;
    ld_use = ld; resume = rs; br_pc = bp; alu_result = alu;
    #1;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Clock edge: the model applies the same cycle's inputs.
  task automatic advance();
    @(posedge clk);
    if (!reset) begin
      mHalted = 1'b0; mRedir = 0; mStall = 0;
    end else if (mHalted) begin
      if (resume) mHalted = 1'b0;
    end else if (ex_valid && halt) begin
      mHalted = 1'b1;
    end else if (ex_valid && (pc_sel || jalr)) begin
      mRedir++;
    end else if (ld_use) begin
      mStall++;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 1, 1, 1, 1, 1, $urandom, $urandom);
      total++;
      if ({pc_src, ifid_we, ifid_flush, idex_flush, redirect_pc} !== {2'd0, 3'b111, 9'd0}) begin
        bad++;
        $display("[TB] FAIL reset_comb: got pc_src=%0d we=%0b iff=%0b idf=%0b rpc=%h, want 0 1 1 1 000",
                 pc_src, ifid_we, ifid_flush, idex_flush, redirect_pc);
      end
      advance();
    end
    idle();
    total++;
    if ({halted, redirect_cnt, stall_cnt} !== {1'b0, 16'd0, 16'd0}) begin
      bad++;
      $display("[TB] FAIL reset_state: got halted=%0b rc=%0d sc=%0d, want 0 0 0",
               halted, redirect_cnt, stall_cnt);
    end
    total++;
    if ({pc_src, ifid_we, ifid_flush, idex_flush} !== {2'd0, 3'b100}) begin
      bad++;
      $display("[TB] FAIL reset_idle: got pc_src=%0d we=%0b iff=%0b idf=%0b, want 0 1 0 0",
               pc_src, ifid_we, ifid_flush, idex_flush);
    end
    advance();
  endtask

  task automatic test_branch();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 32'h0000_0040, 32'h0);
    total++;
    if ({pc_src, redirect_pc, ifid_flush, idex_flush, ifid_we} !== {2'd1, 9'h040, 3'b111}) begin
      bad++;
      $display("[TB] FAIL branch_comb: got pc_src=%0d rpc=%h iff=%0b idf=%0b we=%0b, want 1 040 1 1 1",
               pc_src, redirect_pc, ifid_flush, idex_flush, ifid_we);
    end
    advance();
    idle();
    total++;
    if (redirect_cnt !== 16'd1) begin
      bad++;
      $display("[TB] FAIL branch_count: got %0d want 1", redirect_cnt);
    end
    advance();
  endtask

  task automatic test_jalr();
    longint stallBefore = mStall;
    drive(1, 1, 0, 1, 1, 0, 1, 0, 32'h0000_0100, 32'h0000_0087);
    total++;
    if ({pc_src, redirect_pc} !== {2'd1, 9'h086}) begin
      bad++;
      $display("[TB] FAIL jalr_target: got pc_src=%0d rpc=%h, want 1 086", pc_src, redirect_pc);
    end
    advance();
    idle();
    total++;
    if (stall_cnt !== 16'(stallBefore) || redirect_cnt !== 16'd2) begin
      bad++;
      $display("[TB] FAIL jalr_counts: got sc=%0d rc=%0d, want %0d 2", stall_cnt, redirect_cnt, stallBefore);
    end
    advance();
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
      total++;
      if ({pc_src, ifid_we, ifid_flush, idex_flush} !== {2'd2, 3'b001}) begin
        bad++;
        $display("[TB] FAIL load_use_comb[%0d]: got pc_src=%0d we=%0b iff=%0b idf=%0b, want 2 0 0 1",
                 i, pc_src, ifid_we, ifid_flush, idex_flush);
      end
      advance();
    end
    idle();
    total++;
    if (stall_cnt !== 16'd3) begin
      bad++;
      $display("[TB] FAIL load_use_count: got %0d want 3", stall_cnt);
    end
    advance();
  endtask

  task automatic test_halt_resume();
    logic [15:0] rcHold, scHold;
    drive(1, 1, 1, 0, 0, 1, 0, 1, 32'h0000_0080, 32'h0);
    total++;
    if ({pc_src, ifid_we, ifid_flush, idex_flush, halted} !== {2'd2, 4'b0110}) begin
      bad++;
      $display("[TB] FAIL halt_comb: got pc_src=%0d we=%0b iff=%0b idf=%0b halted=%0b, want 2 0 1 1 0",
               pc_src, ifid_we, ifid_flush, idex_flush, halted);
    end
    advance();
    rcHold = redirect_cnt; scHold = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, i[0], 0, 1, 0, 32'h0000_0010, 32'h0000_0021);
      total++;
      if ({halted, pc_src, ifid_we, ifid_flush, idex_flush} !== {1'b1, 2'd2, 3'b001}) begin
        bad++;
        $display("[TB] FAIL halted_comb[%0d]: got halted=%0b pc_src=%0d we=%0b iff=%0b idf=%0b, want 1 2 0 0 1",
                 i, halted, pc_src, ifid_we, ifid_flush, idex_flush);
      end
      advance();
    end
    total++;
    if (redirect_cnt !== rcHold || stall_cnt !== scHold) begin
      bad++;
      $display("[TB] FAIL halted_counters: got rc=%0d sc=%0d, want %0d %0d",
               redirect_cnt, stall_cnt, rcHold, scHold);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    advance();
    idle();
    total++;
    if ({halted, pc_src, ifid_we} !== {1'b0, 2'd0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL resume: got halted=%0b pc_src=%0d we=%0b, want 0 0 1", halted, pc_src, ifid_we);
    end
    advance();
  endtask

  task automatic test_saturation();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 0, 0, 0, 0, 32'(i * 8), 32'h0);
      advance();
    end
    drive(1, 0, 1, 0, 0, 0, 0, 0, 32'h0000_0044, 32'h0);
    total++;
    if (redirCntS !== 2'd3 || redirect_cnt !== 16'd5) begin
      bad++;
      $display("[TB] FAIL saturation: got small=%0d wide=%0d, want 3 5", redirCntS, redirect_cnt);
    end
    total++;
    if (pc_src !== 2'd0 || redirect_pc !== 9'd0) begin
      bad++;
      $display("[TB] FAIL bubble_ignored: got pc_src=%0d rpc=%h, want 0 000", pc_src, redirect_pc);
    end
    advance();
    idle();
    total++;
    if (redirect_cnt !== 16'd5) begin
      bad++;
      $display("[TB] FAIL bubble_count: got %0d want 5", redirect_cnt);
    end
    advance();
  endtask

  task automatic test_random();
    logic [1:0] ePc;
    logic [8:0] eRpc;
    logic       eWe, eIf, eId;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
            $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom, $urandom);
      expComb(ePc, eRpc, eWe, eIf, eId);
      total++;
      if ({pc_src, redirect_pc, ifid_we, ifid_flush, idex_flush} !== {ePc, eRpc, eWe, eIf, eId}) begin
        bad++;
        $display("[TB] FAIL rand_comb[%0d]: got %0d %h %0b%0b%0b, want %0d %h %0b%0b%0b", i,
                 pc_src, redirect_pc, ifid_we, ifid_flush, idex_flush, ePc, eRpc, eWe, eIf, eId);
      end
      advance();
      total++;
      if ({halted, redirect_cnt, stall_cnt, redirCntS, stallCntS} !==
          {mHalted, 16'(sat(mRedir, 16)), 16'(sat(mStall, 16)), 2'(sat(mRedir, 2)), 2'(sat(mStall, 2))}) begin
        bad++;
        $display("[TB] FAIL rand_state[%0d]: got h=%0b rc=%0d sc=%0d rcs=%0d scs=%0d, want %0b %0d %0d %0d %0d",
                 i, halted, redirect_cnt, stall_cnt, redirCntS, stallCntS, mHalted,
                 sat(mRedir, 16), sat(mStall, 16), sat(mRedir, 2), sat(mStall, 2));
      end
    end
  endtask

  initial begin
    reset = 1'b0; ex_valid = 0; pc_sel = 0; j_sel = 0; jalr = 0; halt = 0;
    ld_use = 0; resume = 0; br_pc = '0; alu_result = '0;
    test_reset();
    test_branch();
    test_jalr();
    test_load_use();
    test_halt_resume();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
